// File: rtl/obb_motion_sched_if.sv
// OBB state store bus: one-cycle-latency slot read plus position write-back.
// master drives rd_en/rd_idx/wr_*; slave returns rd_active, rd_pos_*, rd_vel_*.
interface obb_motion_sched_if #(
    parameter int IDX_W = 3
) ();
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_active;
    logic [31:0]      rd_pos_x;
    logic [31:0]      rd_pos_y;
    logic [31:0]      rd_vel_x;
    logic [31:0]      rd_vel_y;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_pos_x;
    logic [31:0]      wr_pos_y;

    modport master (
        output rd_en, rd_idx,
        input  rd_active, rd_pos_x, rd_pos_y,
        input  rd_vel_x, rd_vel_y,
        output wr_en, wr_idx, wr_pos_x, wr_pos_y
    );

    modport slave (
        input  rd_en, rd_idx,
        output rd_active, rd_pos_x, rd_pos_y,
        output rd_vel_x, rd_vel_y,
        input  wr_en, wr_idx, wr_pos_x, wr_pos_y
    );
endinterface

// File: rtl/obb_motion_sched.sv
// Per-frame motion scheduler: on frame_start, integrates pos += vel*dt for
// every active OBB slot. Ports: clk, reset_n, frame_start, store (bus),
// busy, done, overrun (sticky until reset).
module obb_motion_sched #(
    parameter int NUM_BODIES = 8,
    parameter int IDX_W      = 3,
    parameter int DT_SHIFT   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    obb_motion_sched_if.master store,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    typedef enum logic [2:0] {
        IDLE, READ, CALC, WRITE, DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BODIES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;

    // Velocity has one more fractional bit than position, hence the +1.
    // Overflow shows up as disagreeing top two bits of the 33-bit sum.
    function automatic logic [31:0] integrate(
        input logic [31:0] pos,
        input logic [31:0] vel
    );
        logic [31:0] step;
        logic [32:0] sum;
        step = 32'($signed(vel) >>> (1 + DT_SHIFT));
        sum  = {pos[31], pos} + {step[31], step};
        case (sum[32:31])
            2'b01:   integrate = 32'h7FFF_FFFF;
            2'b10:   integrate = 32'h8000_0000;
            default: integrate = sum[31:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overrun        <= 1'b0;
            store.rd_en    <= 1'b0;
            store.rd_idx   <= '0;
            store.wr_en    <= 1'b0;
            store.wr_idx   <= '0;
            store.wr_pos_x <= '0;
            store.wr_pos_y <= '0;
        end else begin
            store.rd_en <= 1'b0;
            store.wr_en <= 1'b0;
            done        <= 1'b0;
            // busy is high exactly in READ/CALC/WRITE
            if (frame_start && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        idx          <= '0;
                        store.rd_en  <= 1'b1;
                        store.rd_idx <= '0;
                        busy         <= 1'b1;
                        state        <= READ;
                    end
                end
                READ: begin
                    state <= CALC;
                end
                CALC: begin
                    if (store.rd_active) begin
                        store.wr_en    <= 1'b1;
                        store.wr_idx   <= idx;
                        store.wr_pos_x <= integrate(store.rd_pos_x,
                                                    store.rd_vel_x);
                        store.wr_pos_y <= integrate(store.rd_pos_y,
                                                    store.rd_vel_y);
                        state          <= WRITE;
                    end else if (idx == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx          <= idx + 1'b1;
                        store.rd_en  <= 1'b1;
                        store.rd_idx <= idx + 1'b1;
                        state        <= READ;
                    end
                end
                WRITE: begin
                    if (idx == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx          <= idx + 1'b1;
                        store.rd_en  <= 1'b1;
                        store.rd_idx <= idx + 1'b1;
                        state        <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/obb_motion_sched.md
# obb_motion_sched

Per-frame motion scheduler for the OBB physics datapath. On each `frame_start` it walks body slots 0..NUM_BODIES-1 of the OBB state store. For each active body it reads position and velocity, integrates position by velocity scaled by the frame timestep, and writes the saturated result back. It sits between the frame timing logic and the OBB register file, and is the only writer of body position during the integration phase.

## Interface
- `NUM_BODIES`, 8: number of body slots scanned per frame (2..256).
- `IDX_W`, 3: slot index width, equal to clog2(NUM_BODIES).
- `DT_SHIFT`, 4: timestep as a power of two; dt = 2^-DT_SHIFT frames (0..24).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `frame_start` in 1: one-cycle pulse that starts a scan.
- `rd_en` out 1: read request to the OBB store for slot `rd_idx`.
- `rd_idx` out IDX_W: read slot index.
- `rd_active` in 1: slot-valid flag, valid the cycle after `rd_en`.
- `rd_pos_x`, `rd_pos_y` in 32 each: signed 7.25 position, valid the cycle after `rd_en`.
- `rd_vel_x`, `rd_vel_y` in 32 each: signed 6.26 velocity, valid the cycle after `rd_en`.
- `wr_en` out 1: position write strobe.
- `wr_idx` out IDX_W: write slot index.
- `wr_pos_x`, `wr_pos_y` out 32 each: updated signed 7.25 position.
- `busy` out 1: a scan is in progress.
- `done` out 1: one-cycle pulse when a scan completes.
- `overrun` out 1: sticky flag; set when `frame_start` arrives while busy. Cleared only by reset.

## Operation
- FSM states: IDLE, READ, CALC, WRITE, DONE.
- IDLE: on `frame_start`, set idx=0 and go to READ. Otherwise stay in IDLE.
- READ: assert `rd_en` with `rd_idx`=idx. Go to CALC.
- CALC: capture the read data.
  - If `rd_active`=1: register both updated positions and go to WRITE.
  - If `rd_active`=0: no write. If idx=NUM_BODIES-1, go to DONE; otherwise increment idx and go to READ.
- WRITE: assert `wr_en` with `wr_idx`=idx and the registered positions. If idx=NUM_BODIES-1, go to DONE; otherwise increment idx and go to READ.
- DONE: pulse `done` and go to IDLE.
- Arithmetic, applied per axis:
  - step = vel >>> (1+DT_SHIFT). This is an arithmetic shift; the extra 1 aligns 26 fractional bits to 25.
  - sum = sext33(pos) + sext33(step).
  - If sum > 0x7FFFFFFF, output 0x7FFFFFFF. If sum < -2^31, output 0x80000000. Otherwise output sum[31:0].
- `frame_start` while busy is ignored; the scan is not restarted, and `overrun` is set.
- Reset asynchronously forces IDLE, idx=0 and all outputs to 0, including when asserted mid-scan. No partial write completes after reset. The next scan starts at slot 0.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- OBB store read latency is exactly 1 cycle.
- Let `frame_start` be sampled at cycle 0:
  - `busy` rises at cycle 1.
  - An active body costs 3 cycles: READ, CALC, WRITE. An inactive body costs 2 cycles: READ, CALC.
  - With all bodies active, slot i is read at cycle 1+3i and written at cycle 3+3i.
  - `done` is high at cycle 3N+1, with N = NUM_BODIES. `busy` is low from that cycle, and a new `frame_start` is accepted the following cycle.
- `busy` = (state != IDLE && state != DONE).
- `wr_en` and `rd_en` are never high in the same cycle.

## Test plan
- Reset mid-scan: hold `reset_n`=0 at slot 3 WRITE. Required: `wr_en`, `rd_en`, `busy`, `done` and `overrun` all 0 immediately. After release, the next `frame_start` reads slot 0.
- Basic step: DT_SHIFT=4, all slots pos=(0x02000000, 0x00000000), vel=(0x04000000, 0xFC000000). Required: 8 writes of (0x02200000, 0xFFE00000) to slots 0..7 at cycles 3,6,…,24, and `done` at cycle 25.
- Saturation: pos_x=0x7FF00000, vel_x=0x7FFFFFFF → wr_pos_x=0x7FFFFFFF. pos_y=0x80100000, vel_y=0x80000000 → wr_pos_y=0x80000000.
- Inactive skip: slots 2 and 5 have `rd_active`=0. Required: no writes to slots 2 or 5, 6 writes total, `done` at cycle 23.
- Overrun: pulse `frame_start` at cycles 0 and 10. Required: a single scan completes at cycle 25, `overrun`=1 from cycle 11 and stays high, and no restart occurs.
